// File: rtl/router_pkt_src_if.sv
// Command, payload and router-side signals of the router packet source.
// PKT_SRC_ERR_INJECT_EN adds the inj_err command qualifier.
interface router_pkt_src_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_rej;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       err;
    logic       pkt_valid;
    logic [7:0] d_out;
    logic       tx_active;
    logic       pkt_done;
    logic       pkt_err;
`ifdef PKT_SRC_ERR_INJECT_EN
    logic       inj_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, inj_err, pl_valid, pl_data, busy, err,
        output cmd_ready, cmd_rej, pl_ready, pkt_valid, d_out, tx_active, pkt_done, pkt_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, inj_err, pl_valid, pl_data, busy, err,
        input  cmd_ready, cmd_rej, pl_ready, pkt_valid, d_out, tx_active, pkt_done, pkt_err
    );
`else
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data, busy, err,
        output cmd_ready, cmd_rej, pl_ready, pkt_valid, d_out, tx_active, pkt_done, pkt_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data, busy, err,
        input  cmd_ready, cmd_rej, pl_ready, pkt_valid, d_out, tx_active, pkt_done, pkt_err
    );
`endif
endinterface

// File: rtl/router_pkt_src.sv
// Router packet source: buffers payload and frames {len,addr} header, payload and XOR parity.
// Optional PKT_SRC_ERR_INJECT_EN: inj_err at command accept flips the parity LSB.
module router_pkt_src #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned GAP_CYCLES = 3
) (
    input logic              clk,
    input logic              rst,
    router_pkt_src_if.master bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;

    typedef enum logic [2:0] {StIdle, StWait, StHdr, StPay, StPar, StGap} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push, pop;
    logic [7:0]      head;

    logic [1:0]      addr_q;
    logic [5:0]      len_q;
    logic [5:0]      byte_cnt_q;
    logic [3:0]      gap_cnt_q;
    logic [7:0]      d_out_q, parity_q;
    logic            pkt_valid_q, err_acc_q, cmd_rej_q, pkt_done_q, pkt_err_q;
    logic            inj_q;

    logic            cmd_ok, cmd_bad, hdr_load, par_load, gap_load, done;

    // Payload FIFO; writes are accepted in every state so the next packet can be preloaded.
    assign push = bus.pl_valid && bus.pl_ready;
    assign head = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.pl_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // WAIT only leaves once the whole payload is buffered, so this can never fire.
    assert property (@(posedge clk) disable iff (rst) !(pop && count_q == '0));

`ifdef PKT_SRC_ERR_INJECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else if (cmd_ok) begin
            inj_q <= bus.inj_err;
        end
    end
`else
    assign inj_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_ok   = 1'b0;
        cmd_bad  = 1'b0;
        hdr_load = 1'b0;
        pop      = 1'b0;
        par_load = 1'b0;
        gap_load = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == 6'd0 || bus.cmd_addr == 2'd3) begin
                        cmd_bad = 1'b1;
                    end else begin
                        cmd_ok  = 1'b1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (count_q >= CntW'(len_q)) begin
                    hdr_load = 1'b1;
                    state_d  = StHdr;
                end
            end
            StHdr: begin
                if (!bus.busy) begin
                    pop     = 1'b1;
                    state_d = StPay;
                end
            end
            StPay: begin
                if (!bus.busy) begin
                    if (byte_cnt_q < len_q) begin
                        pop = 1'b1;
                    end else begin
                        par_load = 1'b1;
                        state_d  = StPar;
                    end
                end
            end
            StPar: begin
                if (!bus.busy) begin
                    gap_load = 1'b1;
                    state_d  = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            d_out_q     <= '0;
            parity_q    <= '0;
            pkt_valid_q <= 1'b0;
            err_acc_q   <= 1'b0;
            cmd_rej_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            cmd_rej_q  <= cmd_bad;
            pkt_done_q <= done;
            if (cmd_ok) begin
                addr_q <= bus.cmd_addr;
                len_q  <= bus.cmd_len;
            end
            // d_out and pkt_valid only move on an accepted byte, so busy holds them.
            if (hdr_load) begin
                d_out_q     <= {len_q, addr_q};
                parity_q    <= {len_q, addr_q};
                pkt_valid_q <= 1'b1;
            end else if (pop) begin
                d_out_q    <= head;
                parity_q   <= parity_q ^ head;
                byte_cnt_q <= (state_q == StHdr) ? 6'd1 : byte_cnt_q + 6'd1;
            end else if (par_load) begin
                d_out_q     <= parity_q ^ {7'd0, inj_q};
                pkt_valid_q <= 1'b0;
            end else if (gap_load) begin
                d_out_q <= '0;
            end
            if (gap_load) begin
                gap_cnt_q <= 4'(GAP_CYCLES);
                err_acc_q <= 1'b0;
            end else if (state_q == StGap) begin
                err_acc_q <= err_acc_q | bus.err;
                if (gap_cnt_q != 4'd0) gap_cnt_q <= gap_cnt_q - 4'd1;
            end
            if (done) begin
                pkt_err_q <= err_acc_q | bus.err;
            end
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.cmd_rej   = cmd_rej_q;
    assign bus.pl_ready  = (count_q < CntW'(DEPTH));
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.d_out     = d_out_q;
    assign bus.tx_active = state_q inside {StHdr, StPay, StPar, StGap};
    assign bus.pkt_done  = pkt_done_q;
    assign bus.pkt_err   = pkt_err_q;
endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src (DEPTH=64, GAP_CYCLES=3); covers PKT_SRC_ERR_INJECT_EN when
// defined.
module tb_router_pkt_src;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    router_pkt_src_if bus_if ();

    router_pkt_src #(
        .DEPTH      (64),
        .GAP_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus_if.pl_valid = 1'b1;
        bus_if.pl_data  = b;
        tick();
        bus_if.pl_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_len   = len;
        tick();
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (bus_if.pkt_done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("pkt_done_seen", bus_if.pkt_done, 1'b1);
    endtask

    logic [7:0] par;
    logic [7:0] b;
    logic       seen;

    initial begin
        rst              = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = 2'd0;
        bus_if.cmd_len   = 6'd0;
        bus_if.pl_valid  = 1'b0;
        bus_if.pl_data   = 8'h00;
        bus_if.busy      = 1'b0;
        bus_if.err       = 1'b0;
`ifdef PKT_SRC_ERR_INJECT_EN
        bus_if.inj_err   = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset values
        check("rst_cmd_ready", bus_if.cmd_ready, 1'b1);
        check("rst_pl_ready", bus_if.pl_ready, 1'b1);
        check("rst_pkt_valid", bus_if.pkt_valid, 1'b0);
        check("rst_d_out", bus_if.d_out, 8'h00);
        check("rst_tx_active", bus_if.tx_active, 1'b0);
        check("rst_outs", {bus_if.cmd_rej, bus_if.pkt_done, bus_if.pkt_err}, 3'b000);

        // Basic packet: addr=1, len=3
        push(8'h11);
        push(8'h22);
        push(8'h33);
        send_cmd(2'd1, 6'd3);
        check("p1_wait_ready", bus_if.cmd_ready, 1'b0);
        check("p1_wait_valid", bus_if.pkt_valid, 1'b0);
        tick();
        check("p1_hdr", bus_if.d_out, 8'h0D);
        check("p1_hdr_valid", bus_if.pkt_valid, 1'b1);
        check("p1_tx_active", bus_if.tx_active, 1'b1);
        tick();
        check("p1_b0", bus_if.d_out, 8'h11);
        tick();
        check("p1_b1", bus_if.d_out, 8'h22);
        tick();
        check("p1_b2", bus_if.d_out, 8'h33);
        check("p1_b2_valid", bus_if.pkt_valid, 1'b1);
        tick();
        check("p1_par", bus_if.d_out, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33);
        check("p1_par_valid", bus_if.pkt_valid, 1'b0);
        tick();
        check("p1_gap_dout", bus_if.d_out, 8'h00);
        repeat (3) tick();
        check("p1_gap_end", {bus_if.tx_active, bus_if.pkt_done}, 2'b10);
        tick();
        check("p1_done", bus_if.pkt_done, 1'b1);
        check("p1_done_idle", {bus_if.tx_active, bus_if.cmd_ready, bus_if.pkt_err}, 3'b010);
        tick();
        check("p1_done_pulse", bus_if.pkt_done, 1'b0);

        // Back-pressure after header, router flags err during GAP
        push(8'h11);
        push(8'h22);
        push(8'h33);
        send_cmd(2'd1, 6'd3);
        tick();
        check("p2_hdr", bus_if.d_out, 8'h0D);
        tick();
        check("p2_b0_c0", bus_if.d_out, 8'h11);
        bus_if.busy = 1'b1;
        tick();
        check("p2_b0_c1", bus_if.d_out, 8'h11);
        tick();
        check("p2_b0_c2", {bus_if.pkt_valid, bus_if.d_out}, 9'h111);
        bus_if.busy = 1'b0;
        tick();
        check("p2_b1", bus_if.d_out, 8'h22);
        tick();
        check("p2_b2", bus_if.d_out, 8'h33);
        tick();
        check("p2_par", bus_if.d_out, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33);
        tick();
        bus_if.err = 1'b1;
        tick();
        bus_if.err = 1'b0;
        wait_done(10);
        check("p2_pkt_err", bus_if.pkt_err, 1'b1);
        tick();
        check("p2_pkt_err_held", bus_if.pkt_err, 1'b1);

        // Command waits for late payload
        push(8'hA1);
        push(8'hA2);
        send_cmd(2'd2, 6'd4);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_if.pkt_valid) seen = 1'b1;
        end
        check("p3_no_valid_wait", seen, 1'b0);
        check("p3_wait_ready", bus_if.cmd_ready, 1'b0);
        push(8'hA3);
        push(8'hA4);
        check("p3_count4_no_hdr", bus_if.pkt_valid, 1'b0);
        tick();
        check("p3_hdr", {bus_if.pkt_valid, bus_if.d_out}, 9'h112);
        par = 8'h12;
        for (int i = 0; i < 4; i++) begin
            tick();
            b = 8'hA1 + 8'(i);
            check("p3_pay", bus_if.d_out, b);
            par ^= b;
        end
        tick();
        check("p3_par", bus_if.d_out, par);
        wait_done(10);
        check("p3_pkt_err_clear", bus_if.pkt_err, 1'b0);
        tick();

        // Illegal commands
        push(8'h40);
        send_cmd(2'd3, 6'd5);
        check("rej_addr3", {bus_if.cmd_rej, bus_if.cmd_ready}, 2'b11);
        send_cmd(2'd0, 6'd0);
        check("rej_len0", bus_if.cmd_rej, 1'b1);
        tick();
        check("rej_pulse_end", bus_if.cmd_rej, 1'b0);
        check("rej_no_pkt", {bus_if.pkt_valid, bus_if.tx_active}, 2'b00);
        check("rej_count", 16'(dut.count_q), 16'd1);

        // Fill to DEPTH, then drain a max-length packet
        for (int i = 1; i < 63; i++) push(8'h40 + 8'(i));
        check("fill63_ready", bus_if.pl_ready, 1'b1);
        push(8'h7F);
        check("fill64_ready", bus_if.pl_ready, 1'b0);
        push(8'hEE);
        check("full_count", 16'(dut.count_q), 16'd64);
        send_cmd(2'd0, 6'd63);
        tick();
        check("big_hdr", bus_if.d_out, 8'hFC);
        par = 8'hFC;
        for (int i = 0; i < 63; i++) begin
            tick();
            b = 8'h40 + 8'(i);
            check("big_pay", bus_if.d_out, b);
            par ^= b;
        end
        tick();
        check("big_par", bus_if.d_out, par);
        check("big_left", 16'(dut.count_q), 16'd1);
        wait_done(10);
        tick();
        send_cmd(2'd1, 6'd1);
        tick();
        check("last_hdr", bus_if.d_out, 8'h05);
        tick();
        check("last_pay", bus_if.d_out, 8'h7F);
        tick();
        check("last_par", bus_if.d_out, 8'h05 ^ 8'h7F);
        wait_done(10);
        tick();

`ifdef PKT_SRC_ERR_INJECT_EN
        // Injected parity error; router model flags err in GAP
        push(8'h5A);
        bus_if.inj_err = 1'b1;
        send_cmd(2'd2, 6'd1);
        bus_if.inj_err = 1'b0;
        tick();
        check("inj_hdr", bus_if.d_out, 8'h06);
        tick();
        check("inj_pay", bus_if.d_out, 8'h5A);
        tick();
        check("inj_par", bus_if.d_out, 8'h06 ^ 8'h5A ^ 8'h01);
        tick();
        bus_if.err = 1'b1;
        tick();
        bus_if.err = 1'b0;
        wait_done(10);
        check("inj_pkt_err", bus_if.pkt_err, 1'b1);
        tick();
`endif

        // Reset mid-PAY
        for (int i = 1; i <= 5; i++) push(8'(i));
        send_cmd(2'd1, 6'd5);
        tick();
        check("mid_hdr", bus_if.d_out, 8'h15);
        tick();
        tick();
        check("mid_pay", bus_if.d_out, 8'h02);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {bus_if.pkt_valid, bus_if.tx_active}, 2'b00);
        check("mid_rst_dout", bus_if.d_out, 8'h00);
        check("mid_rst_count", 16'(dut.count_q), 16'd0);
        check("mid_rst_ready", bus_if.cmd_ready, 1'b1);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.pkt_done) seen = 1'b1;
        end
        check("mid_rst_no_done", seen, 1'b0);
        send_cmd(2'd0, 6'd1);
        repeat (3) tick();
        check("mid_rst_flushed", {bus_if.pkt_valid, bus_if.cmd_ready}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
